// File: rtl/sbox_word_seq.sv
// sbox_word_seq
// Substitutes every 4-bit lane of a word through one shared, programmable
// 16x4 S-box. The table has a single registered read port, so the lanes are
// processed one per cycle and the finished word is then held until the
// consumer takes it.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset; reloads the table to identity
//   in_valid   input word offered
//   in_ready   input word accepted this cycle when in_valid is high
//   in_data    word to substitute, lane k = in_data[4k+3:4k]
//   out_valid  substituted word available (state DONE)
//   out_ready  consumer takes the result
//   out_data   substituted word
//   cfg_we     table write strobe, honoured only in IDLE
//   cfg_addr   table entry index
//   cfg_data   table entry value
//   busy       high whenever a word is in flight or waiting to be taken
//
// state | meaning
// IDLE  | waiting for a word; table writes allowed
// RUN   | stepping lanes through the table, one lookup per cycle
// DONE  | result held on out_data until out_ready

module sbox_word_seq #(
    parameter int NIBBLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_data,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_addr,
    input  logic [3:0]           cfg_data,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   word_q;
    logic [3:0]     tbl [16];
    logic [3:0]     rd_q;
    logic [3:0]     lane_sel;
    logic           accept;
    logic           tbl_we;
    logic           last_capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        in_ready     = (state == IDLE) && !cfg_we;
        accept       = in_valid && in_ready;
        tbl_we       = (state == IDLE) && cfg_we;
        last_capture = (state == RUN) && (cnt == CW'(NIBBLES));
        out_valid    = (state == DONE);
        busy         = (state != IDLE);
        case (state)
            IDLE:    if (accept)       state_nxt = RUN;
            RUN:     if (last_capture) state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane mux for the lookup address; when cnt has run past the last lane
    // the lookup result is never captured, so the select value is irrelevant.
    always_comb begin
        lane_sel = 4'd0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (cnt == CW'(k)) lane_sel = word_q[4*k +: 4];
        end
    end

    // Datapath: lookup for lane cnt is issued while the result of lane cnt-1
    // (read out of rd_q) is written into its output lane in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            word_q   <= '0;
            rd_q     <= '0;
            out_data <= '0;
            for (int i = 0; i < 16; i++) begin
                tbl[i] <= 4'(i);
            end
        end else begin
            if (tbl_we) begin
                tbl[cfg_addr] <= cfg_data;
            end
            if (accept) begin
                word_q <= in_data;
                cnt    <= '0;
            end else if (state == RUN) begin
                rd_q <= tbl[lane_sel];
                for (int k = 0; k < NIBBLES; k++) begin
                    if (cnt == CW'(k + 1)) out_data[4*k +: 4] <= rd_q;
                end
                if (!last_capture) begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sbox_word_seq.sv
// Directed bench for sbox_word_seq. A word-level model (whole-word table
// substitution plus a fixed result latency) runs beside the DUT and is
// compared every cycle; literal expectations pin the model on the key cases.

module tb_sbox_word_seq;

    localparam int NIBBLES = 8;
    localparam int W       = 4 * NIBBLES;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           cfg_we;
    logic [3:0]     cfg_addr;
    logic [3:0]     cfg_data;
    logic           busy;

    int errors = 0;
    int checks = 0;

    sbox_word_seq #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0]   m_tbl [16];
    logic         m_busy    = 1'b0;
    logic         m_valid   = 1'b0;
    logic [W-1:0] m_data    = '0;
    logic [W-1:0] m_expect  = '0;
    int           m_age     = 0;
    logic         started   = 1'b0;

    function automatic logic [W-1:0] subst(input logic [W-1:0] w);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < NIBBLES; k++) r[4*k +: 4] = m_tbl[w[4*k +: 4]];
        return r;
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_data  = '0;
            m_age   = 0;
            for (int i = 0; i < 16; i++) m_tbl[i] = 4'(i);
        end else if (!m_busy) begin
            if (cfg_we) begin
                m_tbl[cfg_addr] = cfg_data;
            end else if (in_valid) begin
                m_busy   = 1'b1;
                m_age    = 0;
                m_expect = subst(in_data);
            end
        end else if (!m_valid) begin
            m_age++;
            if (m_age == NIBBLES + 1) begin
                m_valid = 1'b1;
                m_data  = m_expect;
            end
        end else if (out_ready) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_busy && !cfg_we)});
            if (!m_busy || m_valid) chk("out_data", out_data, m_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [3:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        repeat (2) tick();
        rst = 1'b0;

        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'h0);

        // identity table, latency and busy
        send(32'h12345678);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_done(n);
        chk("t1_latency", n, 32'd9);
        chk("t1_data", out_data, 32'h12345678);
        consume();
        chk("t1_in_ready_after", {31'd0, in_ready}, 32'd1);

        // inverted table, back-pressure hold
        for (int i = 0; i < 16; i++) cfg_write(4'(i), ~4'(i));
        send(32'h0000FFFF);
        wait_done(n);
        chk("t2_latency", n, 32'd9);
        chk("t2_data", out_data, 32'hFFFF0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t2_hold_data", out_data, 32'hFFFF0000);
            chk("t2_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        consume();
        chk("t2_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("t2_busy_after", {31'd0, busy}, 32'd0);

        // table write during RUN is ignored
        pulse_rst();
        send(32'h00000000);
        tick();
        cfg_we   = 1'b1;
        cfg_addr = 4'h3;
        cfg_data = 4'hA;
        tick();
        tick();
        cfg_we = 1'b0;
        wait_done(n);
        consume();
        send(32'h00000003);
        wait_done(n);
        chk("t3_data", out_data, 32'h00000003);
        consume();

        // reset mid-flight restores identity table
        cfg_write(4'h5, 4'hC);
        send(32'h55555555);
        repeat (4) tick();
        pulse_rst();
        chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
        send(32'h55555555);
        wait_done(n);
        chk("t4_data", out_data, 32'h55555555);
        consume();

        // simultaneous cfg_we and in_valid: write wins, word taken next cycle
        cfg_we   = 1'b1;
        cfg_addr = 4'h7;
        cfg_data = 4'h2;
        in_valid = 1'b1;
        in_data  = 32'h77777777;
        #1;
        chk("t5_in_ready_cfg", {31'd0, in_ready}, 32'd0);
        tick();
        chk("t5_busy_after_write", {31'd0, busy}, 32'd0);
        cfg_we = 1'b0;
        #1;
        chk("t5_in_ready_free", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t5_busy_accept", {31'd0, busy}, 32'd1);
        wait_done(n);
        chk("t5_latency", n, 32'd9);
        chk("t5_data", out_data, 32'h22222222);
        consume();

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
